// File: rtl/text_ram_portb_arbiter_if.sv
// Port-B bus of the text/glyph RAM: two requester channels plus the RAM command/data side.
// The arbiter is the slave; the requesters and the RAM model sit on the master side.
interface text_ram_portb_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              r0_req, r0_we, r0_lock, r0_gnt, r0_rvalid;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata, r0_rdata;
  logic              r1_req, r1_we, r1_lock, r1_gnt, r1_rvalid;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata, r1_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              ram_we;

  modport slave (
    input  r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
    input  ram_rdata,
    output r0_gnt, r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata,
    output ram_addr, ram_wdata, ram_we
  );

  modport master (
    output r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
    output ram_rdata,
    input  r0_gnt, r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata,
    input  ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/text_ram_portb_arbiter.sv
// Round-robin arbiter for port B of the text RAM with bounded burst lock,
// registered RAM command and a {valid, owner} tag pipeline routing read returns.
module text_ram_portb_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic clk,
  input  logic rst,
  text_ram_portb_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {ARB = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_t;

  state_t                   state_q, state_d;
  logic                     prio_q, prio_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]        ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]        ram_wdata_q, ram_wdata_d;
  logic                     ram_we_q, ram_we_d;
  logic [RD_LAT:0]          vld_pipe_q, vld_pipe_d;
  logic [RD_LAT:0]          own_pipe_q, own_pipe_d;

  logic [1:0]               req, we, lock, gnt;
  logic [1:0][ADDR_W-1:0]   addr;
  logic [1:0][DATA_W-1:0]   wdata;
  logic                     win, own, sel;

  assign req   = {bus.r1_req,   bus.r0_req};
  assign we    = {bus.r1_we,    bus.r0_we};
  assign lock  = {bus.r1_lock,  bus.r0_lock};
  assign addr  = {bus.r1_addr,  bus.r0_addr};
  assign wdata = {bus.r1_wdata, bus.r0_wdata};
  assign sel   = gnt[1];

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    gnt     = '0;
    win     = 1'b0;
    own     = (state_q == LOCK1);
    case (state_q)
      ARB: begin
        if (|req) begin
          win      = (&req) ? prio_q : req[1];
          gnt[win] = 1'b1;
          prio_d   = ~win;
          if (lock[win]) begin
            state_d = win ? LOCK1 : LOCK0;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      LOCK0, LOCK1: begin
        // Forced yield wins over the owner's request once the burst is spent.
        if (cnt_q == CNT_MAX && req[~own]) begin
          state_d = ARB;
          prio_d  = ~own;
        end else begin
          if (req[own]) begin
            gnt[own] = 1'b1;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          end
          if (!lock[own]) begin
            state_d = ARB;
            prio_d  = ~own;
          end
        end
      end
      default: state_d = ARB;
    endcase
    if (rst) gnt = '0;
  end

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    if (|gnt) begin
      ram_addr_d  = addr[sel];
      ram_wdata_d = wdata[sel];
      ram_we_d    = we[sel];
    end
    vld_pipe_d = {vld_pipe_q[RD_LAT-1:0], (|gnt) & ~we[sel]};
    own_pipe_d = {own_pipe_q[RD_LAT-1:0], sel};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB;
      prio_q      <= 1'b0;
      cnt_q       <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      vld_pipe_q  <= '0;
      own_pipe_q  <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      vld_pipe_q  <= vld_pipe_d;
      own_pipe_q  <= own_pipe_d;
    end
  end

  // Returns are masked during reset so nothing in flight can leak out.
  assign bus.r0_gnt    = gnt[0];
  assign bus.r1_gnt    = gnt[1];
  assign bus.r0_rvalid = vld_pipe_q[RD_LAT] & ~own_pipe_q[RD_LAT] & ~rst;
  assign bus.r1_rvalid = vld_pipe_q[RD_LAT] &  own_pipe_q[RD_LAT] & ~rst;
  assign bus.r0_rdata  = bus.ram_rdata;
  assign bus.r1_rdata  = bus.ram_rdata;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ram_we    = ram_we_q;
endmodule
